// File: rtl/rd_fwft_stage.sv
// Read-side FWFT output stage: pops the async FIFO core into a 2-entry buffer
// and presents the head word to the consumer with a valid/ready handshake.
module rd_fwft_stage #(
    parameter int data_size = 8
) (
    input  logic                 read_clk_i,
    input  logic                 read_reset_n_i,
    input  logic                 read_empty_i,
    input  logic [data_size-1:0] read_data_i,
    output logic                 read_increment_o,
    input  logic                 read_ready_i,
    output logic                 read_valid_o,
    output logic [data_size-1:0] read_data_o,
    output logic [1:0]           read_level_o
);

    logic [1:0]           count_q, count_d;
    logic [data_size-1:0] entry0_q, entry0_d;
    logic [data_size-1:0] entry1_q, entry1_d;
    logic                 pop;
    logic                 out;

    // Pop depends only on registered occupancy, keeping ready off the increment path.
    assign pop = read_reset_n_i & ~read_empty_i & (count_q != 2'd2);
    assign out = (count_q != 2'd0) & read_ready_i;

    always_comb begin
        count_d  = count_q;
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        case (count_q)
            2'd0: begin
                if (pop) begin
                    entry0_d = read_data_i;
                    count_d  = 2'd1;
                end
            end
            2'd1: begin
                case ({pop, out})
                    2'b10: begin
                        entry1_d = read_data_i;
                        count_d  = 2'd2;
                    end
                    2'b01: count_d = 2'd0;
                    2'b11: entry0_d = read_data_i;
                    default: ;
                endcase
            end
            2'd2: begin
                if (out) begin
                    entry0_d = entry1_q;
                    count_d  = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge read_clk_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            count_q  <= 2'd0;
            entry0_q <= '0;
            entry1_q <= '0;
        end else begin
            count_q  <= count_d;
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
        end
    end

    assign read_increment_o = pop;
    assign read_valid_o     = (count_q != 2'd0);
    assign read_data_o      = entry0_q;
    assign read_level_o     = count_q;

endmodule

// File: tb/tb_rd_fwft_stage.sv
// Directed and scoreboard checks for rd_fwft_stage.
module tb_rd_fwft_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       empty;
    logic [7:0] din;
    logic       incr;
    logic       ready;
    logic       valid;
    logic [7:0] dout;
    logic [1:0] level;

    int errors = 0;
    int checks = 0;

    rd_fwft_stage #(.data_size(8)) dut (
        .read_clk_i      (clk),
        .read_reset_n_i  (rst_n),
        .read_empty_i    (empty),
        .read_data_i     (din),
        .read_increment_o(incr),
        .read_ready_i    (ready),
        .read_valid_o    (valid),
        .read_data_o     (dout),
        .read_level_o    (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] held;
        logic       stalled;

        // 1: reset
        rst_n = 1'b0; empty = 1'b1; din = 8'h00; ready = 1'b0;
        #3;
        chk("rst_valid", valid, 0);
        chk("rst_data", dout, 0);
        chk("rst_level", level, 0);
        chk("rst_incr", incr, 0);
        empty = 1'b0; #1;
        chk("rst_incr_forced", incr, 0);
        empty = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("post_rst_valid", valid, 0);
        chk("post_rst_level", level, 0);
        chk("post_rst_data", dout, 0);

        // 2: single word, stalled then consumed
        empty = 1'b0; din = 8'hA5; #1;
        chk("t2_incr", incr, 1);
        tick();
        empty = 1'b1; #1;
        chk("t2_valid", valid, 1);
        chk("t2_data", dout, 8'hA5);
        chk("t2_level", level, 1);
        chk("t2_incr_empty", incr, 0);
        ready = 1'b1;
        tick();
        chk("t2_drained_valid", valid, 0);
        chk("t2_drained_level", level, 0);
        ready = 1'b0;

        // 3: fill to two, stall, release one
        empty = 1'b0; din = 8'h01; #1;
        chk("t3_incr0", incr, 1);
        tick();
        din = 8'h02;
        chk("t3_level1", level, 1);
        chk("t3_data1", dout, 8'h01);
        tick();
        din = 8'h03; #1;
        chk("t3_level2", level, 2);
        chk("t3_incr_full", incr, 0);
        tick();
        chk("t3_hold_level", level, 2);
        chk("t3_hold_data", dout, 8'h01);
        ready = 1'b1;
        tick();
        ready = 1'b0; #1;
        chk("t3_next_data", dout, 8'h02);
        chk("t3_next_level", level, 1);
        chk("t3_incr_again", incr, 1);
        empty = 1'b1; ready = 1'b1;
        tick();
        chk("t3_drain_level", level, 0);
        ready = 1'b0;

        // 4: streaming one word per cycle
        ready = 1'b1; empty = 1'b0;
        for (int i = 0; i < 16; i++) begin
            din = 8'(i);
            tick();
            chk("t4_data", dout, 32'(i));
            chk("t4_level", level, 1);
        end
        empty = 1'b1;
        tick();
        chk("t4_end_level", level, 0);
        ready = 1'b0;

        // 5: asynchronous reset with two buffered words
        empty = 1'b0; din = 8'h77;
        tick();
        tick();
        empty = 1'b1;
        chk("t5_full", level, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_valid", valid, 0);
        chk("t5_level", level, 0);
        chk("t5_data", dout, 0);
        chk("t5_incr", incr, 0);
        @(negedge clk); rst_n = 1'b1;

        // 6: random traffic against a queue scoreboard
        q.delete();
        stalled = 1'b0; held = 8'h00;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (stalled) chk("t6_stall_data", dout, held);
            empty = 1'($urandom_range(0, 1));
            ready = 1'($urandom_range(0, 1));
            din   = 8'($urandom);
            #1;
            chk("t6_level", level, q.size());
            chk("t6_incr", incr, (!empty && q.size() != 2) ? 1 : 0);
            chk("t6_nopop_empty", incr & empty, 0);
            if (valid && ready) chk("t6_order", dout, q.pop_front());
            if (incr) q.push_back(din);
            stalled = valid && !ready;
            held = dout;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rd_fwft_stage.md
Name: rd_fwft_stage

Overview:
Read-side output stage of the asynchronous FIFO, sitting directly downstream of the read-pointer/empty block in the read clock domain. It drives that block's read increment, captures words from the FIFO memory's combinational read port, and presents them to the consumer as first-word-fall-through data with a valid/ready handshake. A 2-entry output buffer gives full throughput and keeps read_ready_i out of any combinational path to the read increment.

Parameters:
data_size, 8, width of one FIFO data word

Ports:
read_clk_i  input  1  read-domain clock
read_reset_n_i  input  1  asynchronous active-low reset, read domain
read_empty_i  input  1  FIFO empty flag from the read-pointer/empty block
read_data_i  input  data_size  FIFO memory read data at the current read address (combinational read port)
read_increment_o  output  1  pop request to the read-pointer/empty block
read_ready_i  input  1  consumer ready
read_valid_o  output  1  read_data_o holds a valid word
read_data_o  output  data_size  oldest buffered word
read_level_o  output  2  buffer occupancy, 0..2

Behaviour:
- Clock read_clk_i. Reset read_reset_n_i is asynchronous and active-low.
- State: count (0..2), entry0 (head), entry1. All state resets asynchronously to 0.
- Reset values: read_valid_o=0, read_data_o=0, read_level_o=0, read_increment_o=0.
- pop = read_increment_o = ~read_empty_i & (count != 2). This is combinational from read_empty_i and registered count only, with no dependency on read_ready_i. It is forced to 0 while read_reset_n_i is low.
- out = read_valid_o & read_ready_i. read_ready_i is ignored when read_valid_o=0.
- On a pop edge, read_data_i is sampled on the same edge at which the core advances its pointer.
- read_valid_o = (count != 0). read_data_o = entry0. read_level_o = count. All are driven from registers.
- Transitions at posedge (pop, out):
  - count 0, pop: entry0<=read_data_i, count 1.
  - count 1, pop only: entry1<=read_data_i, count 2.
  - count 1, out only: count 0.
  - count 1, pop and out: entry0<=read_data_i, count 1.
  - count 2, out: entry0<=entry1, count 1. Pop is impossible in this state.
  - count 2, no out: hold. read_increment_o stays 0 regardless of read_empty_i.
  - No pop, no out: hold.
- Latency:
  - The core empty flag falls after edge N, so pop is high during cycle N.
  - The word is captured at edge N+1, and read_valid_o=1 from edge N+1.
  - Minimum empty-to-valid latency is 1 cycle.
- Throughput: 1 word/cycle when the consumer holds ready high and the FIFO is non-empty.
- Hold rule: while read_valid_o=1 and read_ready_i=0, read_data_o and read_valid_o are stable.
- Ordering: words leave in exactly the order popped. No drop, no duplication.
- Never pops while read_empty_i=1, so there is no underflow. Never accepts a third word, so there is no overflow.
- Reset mid-operation: buffered words are discarded and count goes to 0 immediately on reset assertion, not at the next edge. The stage is reset together with the core read domain.

Test Plan:
1. Reset asserted, read_empty_i=1 -> read_valid_o=0, read_data_o=0, read_level_o=0, read_increment_o=0. Release reset -> outputs unchanged.
2. read_empty_i low for one cycle with read_data_i=0xA5, read_ready_i=0 -> read_increment_o=1 that cycle. Next cycle read_valid_o=1, read_data_o=0xA5, read_level_o=1. Then read_ready_i=1 -> read_valid_o=0 after the next edge.
3. read_empty_i held low, read_data_i=0x01,0x02,0x03 on successive pops, read_ready_i=0 -> two pops, read_level_o=2, read_increment_o=0, read_data_o=0x01 held. One cycle of read_ready_i=1 -> read_data_o=0x02, read_level_o=1, read_increment_o=1 again.
4. Streaming: read_ready_i=1, read_empty_i=0, read_data_i incrementing 0x00..0x0F -> one word per cycle out in order 0x00..0x0F, read_level_o stays 1.
5. read_level_o=2, assert read_reset_n_i=0 mid-cycle -> read_valid_o=0 and read_level_o=0 immediately, before the next clock edge.
6. Randomized read_empty_i and read_ready_i over 1000 cycles with a scoreboard -> output sequence equals popped sequence, no pop while read_empty_i=1, read_data_o stable during stalls.
